sr_reg_bank: RTL and testbench

Parametrised multi-channel successor to the single-bit SR flip-flop: a bank of WIDTH independent set/reset bits sharing one clock and reset. Each bit has a clock enable and a compile-time choice of how a simultaneous set+reset is resolved. The bank also provides registered edge pulses per bit and a sticky conflict monitor with a saturating event counter. It is intended as a status/flag register bank for control logic that previously instantiated individual SR cells.

---
 rtl/sr_pkg.sv | 37 +++
 rtl/sr_cell.sv | 59 +++++
 rtl/sr_reg_bank.sv | 80 ++++++++
 tb/tb_sr_reg_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the set/reset flag bank: S=R=1 resolution modes and
// the helpers used by the channel cells and the conflict counter.
package sr_pkg;

  typedef enum logic [2:0] {
    SR_FORCE0 = 3'd0,
    SR_SETDOM = 3'd1,
    SR_RSTDOM = 3'd2,
    SR_TOGGLE = 3'd3,
    SR_HOLD   = 3'd4
  } sr_mode_e;

  // Popcount result width for the widest legal bank (64 channels).
  localparam int POP_W = 7;

  function automatic logic [POP_W-1:0] popcount(input logic [63:0] vec);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + POP_W'(vec[i]);
    end
    return cnt;
  endfunction

  // Next q when both set and reset are asserted on an enabled channel.
  function automatic logic resolve_both(input int mode, input logic q_cur);
    logic res;
    case (sr_mode_e'(mode[2:0]))
      SR_SETDOM: res = 1'b1;
      SR_TOGGLE: res = ~q_cur;
      SR_HOLD:   res = q_cur;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset channel: flag bit, previous-value register for edge pulses,
// and a sticky conflict bit.
module sr_cell
  import sr_pkg::*;
#(
  parameter int   MODE = 0,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic conflict_clr,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic conflict,
  output logic evt
);

  logic q_d;
  logic q_nxt;

  assign evt = en & s & r;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    q_nxt = q;
    if (en) begin
      case ({s, r})
        2'b10:   q_nxt = 1'b1;
        2'b01:   q_nxt = 1'b0;
        2'b11:   q_nxt = resolve_both(MODE, q);
        default: q_nxt = q;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= INIT;
      q_d      <= INIT;
      conflict <= 1'b0;
    end else begin
      q        <= q_nxt;
      q_d      <= q;
      conflict <= conflict_clr ? evt : (conflict | evt);
    end
  end

  // q_d equals q after reset, so reset itself never produces a pulse.
  assign q_rise = q & ~q_d;
  assign q_fall = ~q & q_d;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent set/reset flags with edge pulses, sticky
// per-channel conflict flags and a saturating conflict event counter.
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_reg_bank: WIDTH must be in 1..64");
  end
  if (MODE < 0 || MODE > 4) begin : g_bad_mode
    $error("sr_reg_bank: MODE must be in 0..4");
  end
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("sr_reg_bank: CNT_W must be in 2..16");
  end

  logic [WIDTH-1:0] evt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE (MODE),
      .INIT (INIT[i])
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .en           (en[i]),
      .s            (s[i]),
      .r            (r[i]),
      .conflict_clr (conflict_clr),
      .q            (q[i]),
      .q_rise       (q_rise[i]),
      .q_fall       (q_fall[i]),
      .conflict     (conflict[i]),
      .evt          (evt[i])
    );
  end

  // The sum is wide enough for both the counter and a full-bank popcount,
  // so narrow counters on wide banks still clamp instead of wrapping.
  localparam int               SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [POP_W-1:0] evt_pop;
  logic [SUM_W-1:0] cnt_base;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    evt_pop  = popcount(64'(evt));
    cnt_base = conflict_clr ? '0 : SUM_W'(conflict_cnt);
    cnt_sum  = cnt_base + SUM_W'(evt_pop);
    cnt_nxt  = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else begin
      conflict_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Self-checking bench: five banks (one per MODE) share stimulus and are
// compared every cycle against a behavioural model of the flag rules.
module tb_sr_reg_bank;

  localparam int         NM    = 5;
  localparam logic [7:0] INITV = 8'hA5;
  localparam int         CMAX  = 15;

  logic       clk;
  logic       reset;
  logic [7:0] en_v, s_v, r_v;
  logic       clr_v;

  logic [7:0] q_o    [NM];
  logic [7:0] rise_o [NM];
  logic [7:0] fall_o [NM];
  logic [7:0] conf_o [NM];
  logic [3:0] cnt_o  [NM];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    sr_reg_bank #(
      .WIDTH (8),
      .MODE  (g),
      .INIT  (INITV),
      .CNT_W (4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en_v),
      .s            (s_v),
      .r            (r_v),
      .conflict_clr (clr_v),
      .q            (q_o[g]),
      .q_rise       (rise_o[g]),
      .q_fall       (fall_o[g]),
      .conflict     (conf_o[g]),
      .conflict_cnt (cnt_o[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq    [NM];
  logic [7:0] mprev [NM];
  logic [7:0] mconf [NM];
  int         mcnt  [NM];

  function automatic logic [7:0] model_next(input int mode, input logic [7:0] qv,
                                            input logic [7:0] e, input logic [7:0] sv,
                                            input logic [7:0] rv);
    logic [7:0] n;
    n = qv;
    for (int b = 0; b < 8; b++) begin
      if (e[b]) begin
        if (sv[b] && !rv[b])      n[b] = 1'b1;
        else if (!sv[b] && rv[b]) n[b] = 1'b0;
        else if (sv[b] && rv[b]) begin
          if (mode == 1)      n[b] = 1'b1;
          else if (mode == 3) n[b] = ~qv[b];
          else if (mode == 4) n[b] = qv[b];
          else                n[b] = 1'b0;
        end
      end
    end
    return n;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NM; m++) begin
        mq[m]    <= INITV;
        mprev[m] <= INITV;
        mconf[m] <= 8'h00;
        mcnt[m]  <= 0;
      end
    end else begin
      for (int m = 0; m < NM; m++) begin
        mprev[m] <= mq[m];
        mq[m]    <= model_next(m, mq[m], en_v, s_v, r_v);
        mconf[m] <= clr_v ? (en_v & s_v & r_v) : (mconf[m] | (en_v & s_v & r_v));
        mcnt[m]  <= clr_v ? sat($countones(en_v & s_v & r_v))
                          : sat(mcnt[m] + $countones(en_v & s_v & r_v));
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      check($sformatf("m%0d q", m),        16'(q_o[m]),    16'(mq[m]));
      check($sformatf("m%0d q_rise", m),   16'(rise_o[m]), 16'(mq[m] & ~mprev[m]));
      check($sformatf("m%0d q_fall", m),   16'(fall_o[m]), 16'(~mq[m] & mprev[m]));
      check($sformatf("m%0d conflict", m), 16'(conf_o[m]), 16'(mconf[m]));
      check($sformatf("m%0d cnt", m),      16'(cnt_o[m]),  16'(mcnt[m]));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic cyc(input logic [7:0] e, input logic [7:0] sv, input logic [7:0] rv,
                     input logic c);
    en_v  = e;
    s_v   = sv;
    r_v   = rv;
    clr_v = c;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int m = 0; m < NM; m++) begin
      check($sformatf("%s m%0d q", tag, m),    16'(q_o[m]),    16'(INITV));
      check($sformatf("%s m%0d rise", tag, m), 16'(rise_o[m]), 16'h0);
      check($sformatf("%s m%0d fall", tag, m), 16'(fall_o[m]), 16'h0);
      check($sformatf("%s m%0d conf", tag, m), 16'(conf_o[m]), 16'h0);
      check($sformatf("%s m%0d cnt", tag, m),  16'(cnt_o[m]),  16'h0);
    end
  endtask

  logic [2:0] mode_seq [NM];
  logic [7:0] held_q   [NM];
  logic [3:0] sat_seq  [3];

  initial begin
    mode_seq = '{3'b000, 3'b111, 3'b000, 3'b010, 3'b111};
    held_q   = '{8'hA4, 8'hA5, 8'hA4, 8'hA4, 8'hA5};
    sat_seq  = '{4'd8, 4'd15, 4'd15};

    reset = 1'b1;
    en_v = '0; s_v = '0; r_v = '0; clr_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) begin
      cyc(8'h00, 8'h00, 8'h00, 1'b0);
      check_reset_vals("post_release");
    end

    // Clear bit 0 (INIT has it set), then set it again.
    cyc(8'hFF, 8'h00, 8'h01, 1'b0);
    check("clr q0", 16'(q_o[0]), 16'hA4);
    check("clr fall", 16'(fall_o[0]), 16'h01);
    cyc(8'h00, 8'h00, 8'h00, 1'b0);
    check("fall one cycle", 16'(fall_o[0]), 16'h00);
    cyc(8'hFF, 8'h01, 8'h00, 1'b0);
    check("set q0", 16'(q_o[0]), 16'hA5);
    check("set rise", 16'(rise_o[0]), 16'h01);
    cyc(8'h00, 8'h00, 8'h00, 1'b0);
    check("rise one cycle", 16'(rise_o[0]), 16'h00);

    // S=R=1 on channel 0 for three cycles in every mode.
    for (int k = 0; k < 3; k++) begin
      cyc(8'h01, 8'h01, 8'h01, 1'b0);
      for (int m = 0; m < NM; m++)
        check($sformatf("mode%0d step%0d q0", m, k), 16'(q_o[m][0]), 16'(mode_seq[m][2-k]));
    end
    for (int m = 0; m < NM; m++) begin
      check($sformatf("mode%0d conflict", m), 16'(conf_o[m]), 16'h01);
      check($sformatf("mode%0d cnt", m),      16'(cnt_o[m]),  16'd3);
    end

    // Disabled channels ignore S/R and record no conflicts.
    for (int k = 0; k < 5; k++) begin
      cyc(8'h00, 8'hFF, 8'hFF, k == 0);
      for (int m = 0; m < NM; m++) begin
        check($sformatf("dis m%0d q", m),    16'(q_o[m]),    16'(held_q[m]));
        check($sformatf("dis m%0d conf", m), 16'(conf_o[m]), 16'h0);
        check($sformatf("dis m%0d cnt", m),  16'(cnt_o[m]),  16'h0);
      end
    end

    // Eight conflicts per cycle into a 4-bit counter.
    for (int k = 0; k < 3; k++) begin
      cyc(8'hFF, 8'hFF, 8'hFF, 1'b0);
      check($sformatf("sat step%0d", k), 16'(cnt_o[0]), 16'(sat_seq[k]));
    end

    // Clear and new events in the same cycle, then clear alone.
    cyc(8'h03, 8'h03, 8'h03, 1'b1);
    check("clr+evt conf", 16'(conf_o[2]), 16'h03);
    check("clr+evt cnt",  16'(cnt_o[2]),  16'd2);
    cyc(8'h00, 8'h00, 8'h00, 1'b1);
    check("clr conf", 16'(conf_o[2]), 16'h00);
    check("clr cnt",  16'(cnt_o[2]),  16'd0);

    // Asynchronous reset in the middle of a cycle.
    cyc(8'h03, 8'h03, 8'h03, 1'b0);
    cyc(8'hFF, 8'h5A, 8'h00, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    cyc(8'h00, 8'h00, 8'h00, 1'b0);
    check_reset_vals("async_release");

    for (int k = 0; k < 1500; k++) begin
      cyc(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
